// File: rtl/pipelined_control_unit_if.sv
// ID-stage request / ID-EX control bundle bus between the pipeline datapath and the control unit.
// The datapath (master) drives the ID-stage fields; the control unit (slave) returns the registered bundle.
interface pipelined_control_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
);
  logic                  instr_valid;
  logic [6:0]            opcode;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic                  branch_taken;
  logic                  ex_valid;
  logic                  ex_branch;
  logic                  ex_jump;
  logic                  ex_memtoreg;
  logic                  ex_memwrite;
  logic                  ex_alusrc;
  logic                  ex_regwrite;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  stall;
  logic                  flush;

  modport master (
    output instr_valid, opcode, rs1, rs2, rd, branch_taken,
    input  ex_valid, ex_branch, ex_jump, ex_memtoreg, ex_memwrite, ex_alusrc,
           ex_regwrite, ex_aluop, ex_rd, stall, flush
  );

  modport slave (
    input  instr_valid, opcode, rs1, rs2, rd, branch_taken,
    output ex_valid, ex_branch, ex_jump, ex_memtoreg, ex_memwrite, ex_alusrc,
           ex_regwrite, ex_aluop, ex_rd, stall, flush
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// RV32I decode/control: opcode decode into the ID/EX control register, load-use stall, branch flush FSM.
//   state | meaning
//   RUN   | normal decode; stalls on load-use, honours taken branch/jump
//   FLUSH | squashing wrong-path fetches; counter counts remaining cycles
module pipelined_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int EXT_OPS      = 1,
  parameter int ALUOP_W      = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_control_unit_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [2:0] CNT_INIT  = 3'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic       known, use_rs1, use_rs2;
  logic       d_branch, d_jump, d_memtoreg, d_memwrite, d_alusrc, d_regwrite;
  logic [1:0] d_aluop;
  logic       hazard, honour, load_ok;

  always_comb begin
    known      = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    d_branch   = 1'b0;
    d_jump     = 1'b0;
    d_memtoreg = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_regwrite = 1'b0;
    d_aluop    = 2'b00;
    case (bus.opcode)
      OP_LOAD:   begin known = 1'b1; use_rs1 = 1'b1; d_alusrc = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1; end
      OP_STORE:  begin known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_alusrc = 1'b1; d_memwrite = 1'b1; end
      OP_R:      begin known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_regwrite = 1'b1; d_aluop = 2'b10; end
      OP_BRANCH: begin known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; d_branch = 1'b1; d_aluop = 2'b01; end
      OP_IALU:   begin known = 1'b1; use_rs1 = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 2'b11; end
      OP_JAL: if (EXT_OPS != 0) begin
        known = 1'b1; d_jump = 1'b1; d_regwrite = 1'b1;
      end
      OP_JALR: if (EXT_OPS != 0) begin
        known = 1'b1; use_rs1 = 1'b1; d_jump = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1;
      end
      OP_LUI, OP_AUIPC: if (EXT_OPS != 0) begin
        known = 1'b1; d_alusrc = 1'b1; d_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    hazard = (state_q == RUN) && bus.instr_valid && bus.ex_valid && bus.ex_memtoreg &&
             (bus.ex_rd != '0) &&
             ((use_rs1 && (bus.ex_rd == bus.rs1)) || (use_rs2 && (bus.ex_rd == bus.rs2)));
    honour = (state_q == RUN) && bus.branch_taken && bus.ex_valid && (bus.ex_branch || bus.ex_jump);
    bus.flush = honour || (state_q == FLUSH);
    // flush wins: a squashed instruction must not also hold the PC
    bus.stall = hazard && !bus.flush;
    load_ok   = bus.instr_valid && known && !bus.flush && !bus.stall;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: if (honour && (FLUSH_CYCLES > 1)) begin
        state_d = FLUSH;
        cnt_d   = CNT_INIT;
      end
      FLUSH: begin
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_branch   <= 1'b0;
      bus.ex_jump     <= 1'b0;
      bus.ex_memtoreg <= 1'b0;
      bus.ex_memwrite <= 1'b0;
      bus.ex_alusrc   <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_aluop    <= '0;
      bus.ex_rd       <= '0;
    end else begin
      bus.ex_valid    <= load_ok;
      bus.ex_branch   <= load_ok && d_branch;
      bus.ex_jump     <= load_ok && d_jump;
      bus.ex_memtoreg <= load_ok && d_memtoreg;
      bus.ex_memwrite <= load_ok && d_memwrite;
      bus.ex_alusrc   <= load_ok && d_alusrc;
      bus.ex_regwrite <= load_ok && d_regwrite;
      bus.ex_aluop    <= load_ok ? ALUOP_W'(d_aluop) : '0;
      bus.ex_rd       <= load_ok ? bus.rd : '0;
    end
  end
endmodule
